// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared width and ALU opcode constants for the Y86-64 execute stage
package y86_pkg;
  localparam int WIDTH = 64;

  // Opcode is {s0,s1}
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b11;
endpackage

// File: rtl/y86_addsub64.sv
// rtl/y86_addsub64.sv - combinational adder/subtractor: x + (y ^ {sub}) + sub, with signed overflow
module y86_addsub64 #(
  parameter int WIDTH = y86_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);
  logic [WIDTH-1:0] y_eff;

  assign y_eff = y ^ {WIDTH{sub}};
  assign sum   = x + y_eff + {{(WIDTH-1){1'b0}}, sub};

  // Overflow judged on the effective (possibly inverted) operand, so one rule covers add and subtract
  assign overflow = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
endmodule

// File: rtl/y86_alu64.sv
// rtl/y86_alu64.sv - registered four-function Y86-64 ALU with overflow, zero and sign flags
module y86_alu64
  import y86_pkg::*;
#(
  parameter int WIDTH = y86_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] xor_out,
  output logic             overflow,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf
);
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] xor_res;
  logic [WIDTH-1:0] sel_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic             sel_ovf;

  y86_addsub64 #(.WIDTH(WIDTH)) u_add (
    .x(a), .y(b), .sub(1'b0), .sum(add_res), .overflow(add_ovf)
  );

  // subq computes b - a, hence the swapped operands
  y86_addsub64 #(.WIDTH(WIDTH)) u_sub (
    .x(b), .y(a), .sub(1'b1), .sum(sub_res), .overflow(sub_ovf)
  );

  assign and_res = a & b;
  assign xor_res = a ^ b;

  always_comb begin
    sel_res = add_res;
    sel_ovf = add_ovf;
    case ({s0, s1})
      ALU_ADD: begin sel_res = add_res; sel_ovf = add_ovf; end
      ALU_SUB: begin sel_res = sub_res; sel_ovf = sub_ovf; end
      ALU_AND: begin sel_res = and_res; sel_ovf = 1'b0;    end
      ALU_XOR: begin sel_res = xor_res; sel_ovf = 1'b0;    end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      diff     <= '0;
      and_out  <= '0;
      xor_out  <= '0;
      overflow <= 1'b0;
      result   <= '0;
      zf       <= 1'b0;
      sf       <= 1'b0;
    end else begin
      sum      <= add_res;
      diff     <= sub_res;
      and_out  <= and_res;
      xor_out  <= xor_res;
      overflow <= sel_ovf;
      result   <= sel_res;
      zf       <= (sel_res == '0);
      sf       <= sel_res[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_y86_alu64.sv
// tb/tb_y86_alu64.sv - self-checking bench for y86_alu64: cycle model plus directed literal vectors
module tb_y86_alu64;
  logic        clk = 1'b0;
  logic        rst;
  logic        s0, s1;
  logic [63:0] a, b;
  logic [63:0] sum, diff, and_out, xor_out, result;
  logic        overflow, zf, sf;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic [63:0] diff;
    logic [63:0] and_out;
    logic [63:0] xor_out;
    logic [63:0] result;
    logic        overflow;
    logic        zf;
    logic        sf;
  } exp_t;

  localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] SMIN = 65'sh1_8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  exp_t exp_q;
  bit   model_valid = 1'b0;

  y86_alu64 dut (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1), .a(a), .b(b),
    .sum(sum), .diff(diff), .and_out(and_out), .xor_out(xor_out),
    .overflow(overflow), .result(result), .zf(zf), .sf(sf)
  );

  always #5 clk = ~clk;

  // Overflow here means the exact signed result falls outside the 64-bit signed range
  function automatic exp_t model(input logic r, input logic [1:0] op,
                                 input logic [63:0] va, input logic [63:0] vb);
    exp_t e;
    logic signed [64:0] sa, sb, exact_add, exact_sub;
    e = '0;
    if (r) return e;
    sa = $signed({va[63], va});
    sb = $signed({vb[63], vb});
    exact_add = sa + sb;
    exact_sub = sb - sa;
    e.sum     = va + vb;
    e.diff    = vb - va;
    e.and_out = va & vb;
    e.xor_out = va ^ vb;
    case (op)
      2'b00: begin e.result = e.sum;     e.overflow = (exact_add > SMAX) || (exact_add < SMIN); end
      2'b10: begin e.result = e.diff;    e.overflow = (exact_sub > SMAX) || (exact_sub < SMIN); end
      2'b01: begin e.result = e.and_out; e.overflow = 1'b0; end
      default: begin e.result = e.xor_out; e.overflow = 1'b0; end
    endcase
    e.zf = (e.result == 64'd0);
    e.sf = ($signed(e.result) < 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  always @(posedge clk) begin
    exp_q       <= model(rst, {s0, s1}, a, b);
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_sum",      sum,             exp_q.sum);
      chk("cyc_diff",     diff,            exp_q.diff);
      chk("cyc_and",      and_out,         exp_q.and_out);
      chk("cyc_xor",      xor_out,         exp_q.xor_out);
      chk("cyc_result",   result,          exp_q.result);
      chk("cyc_overflow", {63'd0, overflow}, {63'd0, exp_q.overflow});
      chk("cyc_zf",       {63'd0, zf},     {63'd0, exp_q.zf});
      chk("cyc_sf",       {63'd0, sf},     {63'd0, exp_q.sf});
    end
  end

  // Drive one operation, then return just after the edge that registers it
  task automatic step(input logic r, input logic [1:0] op, input logic [63:0] va, input logic [63:0] vb);
    rst = r;
    {s0, s1} = op;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_sum"},  sum, 64'd0);
    chk({name, "_diff"}, diff, 64'd0);
    chk({name, "_and"},  and_out, 64'd0);
    chk({name, "_xor"},  xor_out, 64'd0);
    chk({name, "_res"},  result, 64'd0);
    chk({name, "_flags"}, {61'd0, overflow, zf, sf}, 64'd0);
  endtask

  initial begin
    step(1'b1, 2'b00, 64'd5, 64'd7);
    chk_zero("rst1");
    step(1'b1, 2'b00, 64'd5, 64'd7);
    chk_zero("rst2");

    step(1'b0, 2'b00, 64'd5, 64'd7);
    chk("first_sum",  sum, 64'd12);
    chk("first_diff", diff, 64'd2);
    chk("first_and",  and_out, 64'd5);
    chk("first_xor",  xor_out, 64'd2);
    chk("first_res",  result, 64'd12);

    step(1'b0, 2'b00, MAX64, 64'd1);
    chk("addovf_sum", sum, MIN64);
    chk("addovf_flags", {61'd0, overflow, zf, sf}, 64'b101);

    step(1'b0, 2'b00, ONES, ONES);
    chk("negneg_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("negneg_ovf", {63'd0, overflow}, 64'd0);

    step(1'b0, 2'b00, ONES, 64'd1);
    chk("wrap_sum", sum, 64'd0);
    chk("wrap_flags", {61'd0, overflow, zf, sf}, 64'b010);

    step(1'b0, 2'b10, 64'd1, MIN64);
    chk("subovf_diff", diff, MAX64);
    chk("subovf_res",  result, MAX64);
    chk("subovf_flags", {61'd0, overflow, zf, sf}, 64'b100);

    step(1'b0, 2'b10, 64'h1234, 64'h1234);
    chk("subeq_diff", diff, 64'd0);
    chk("subeq_flags", {61'd0, overflow, zf, sf}, 64'b010);

    step(1'b0, 2'b01, 64'hF0F0, 64'hFF00);
    chk("and_res", result, 64'hF000);
    chk("and_ovf", {63'd0, overflow}, 64'd0);

    step(1'b0, 2'b11, 64'hF0F0, 64'hFF00);
    chk("xor_res", result, 64'h0FF0);
    chk("xor_ovf", {63'd0, overflow}, 64'd0);

    // Back-to-back: new opcode and operands every cycle, reset in the third
    step(1'b0, 2'b00, 64'd3, 64'd4);
    chk("b2b1_res", result, 64'd7);
    step(1'b0, 2'b10, 64'd3, 64'd10);
    chk("b2b2_res", result, 64'd7);
    step(1'b1, 2'b11, 64'hAAAA, 64'h5555);
    chk_zero("b2b3");
    step(1'b0, 2'b01, 64'd6, 64'd3);
    chk("b2b4_res", result, 64'd2);
    chk("b2b4_sum", sum, 64'd9);

    step(1'b0, 2'b10, 64'd5, 64'd3);
    chk("subneg_res", result, ONES - 64'd1);
    chk("subneg_flags", {61'd0, overflow, zf, sf}, 64'b001);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/y86_alu64.md
Name: y86_alu64

Overview:
- 64-bit, four-function integer ALU for the Y86-64 execute stage: add, subtract, AND, XOR.
- All four results are computed in parallel and registered on every clock edge.
- A 2-bit function select determines which operation drives the overflow flag, the selected result, and the zero/sign flags.
- Sits under the execute stage, which instantiates it once per operation and consumes the registered results and flags for condition-code generation.

Parameters:
- WIDTH, 64, operand and result width in bits. Overflow and sign use bit WIDTH-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s0  in  1  function select, high bit of opcode {s0,s1}
- s1  in  1  function select, low bit of opcode {s0,s1}
- a  in  WIDTH  operand A (Y86 valA / valC)
- b  in  WIDTH  operand B (Y86 valB)
- sum  out  WIDTH  registered a + b
- diff  out  WIDTH  registered b - a
- and_out  out  WIDTH  registered a & b
- xor_out  out  WIDTH  registered a ^ b
- overflow  out  1  registered signed overflow of the selected operation
- result  out  WIDTH  registered result of the selected operation
- zf  out  1  registered, 1 when result is 0
- sf  out  1  registered, equals result[WIDTH-1]

Behaviour:
- Opcode {s0,s1}:
  - 00: ADD, result = sum
  - 10: SUB, result = diff
  - 01: AND, result = and_out
  - 11: XOR, result = xor_out
- Latency: 1 cycle. Inputs sampled at rising edge N appear on outputs after edge N. No handshake; a new operation is accepted every cycle.
- sum, diff, and_out and xor_out are all updated every cycle, regardless of the opcode.
- Arithmetic is modulo 2^WIDTH. Carry-out and borrow are discarded.
- diff is b - a (Y86 subq semantics), not a - b.
- ADD overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
- SUB overflow = (b[MSB] != a[MSB]) && (diff[MSB] != b[MSB]).
- AND and XOR: overflow = 0.
- zf and sf are derived from the selected result in the same cycle as result.
- Reset: when rst is high at a rising edge, all outputs go to 0 (zf also 0). rst takes priority over any input. Reset mid-stream discards the in-flight operation. The first valid output appears on the edge after rst is sampled low.
- Outputs hold their values only as long as the inputs are held; there are no enable or hold registers.
- Boundary cases:
  - 0x7FFF..F + 1 → overflow 1, sf 1.
  - 0x8000..0 - 1 (b=MIN, a=1) → overflow 1, diff 0x7FFF..F.
  - a == b on SUB → zf 1, overflow 0.
  - All-ones + 1 → sum 0, zf 1, overflow 0.

Decomposition:
- Shared package y86_pkg: WIDTH default, 2-bit ALU opcode constants (ALU_ADD=2'b00, ALU_SUB=2'b10, ALU_AND=2'b01, ALU_XOR=2'b11).
- One sub-module, y86_addsub64: a combinational ripple/prefix adder.
  - Computes x + (y ^ {WIDTH{sub}}) + sub.
  - Returns sum and signed overflow.
  - Instantiated twice: once for ADD (x=a, y=b, sub=0) and once for SUB (x=b, y=a, sub=1).
- Logic ops, selection, flags and output registers live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with a=5, b=7 → all outputs 0. Release rst; next edge → sum=12, diff=2, and_out=5, xor_out=2.
- ADD overflow: opcode 00, a=0x7FFFFFFFFFFFFFFF, b=1 → sum=0x8000000000000000, overflow=1, sf=1, zf=0. Then a=b=0xFFFFFFFFFFFFFFFF → sum=0xFFFFFFFFFFFFFFFE, overflow=0.
- SUB: opcode 10, a=1, b=0x8000000000000000 → diff=0x7FFFFFFFFFFFFFFF, overflow=1. Then a=b=0x1234 → diff=0, zf=1, overflow=0.
- Logic ops: a=0xF0F0, b=0xFF00. Opcode 01 → result=0xF000, overflow=0. Opcode 11 → result=0x0FF0, overflow=0.
- Latency and back-to-back: change opcode and operands every cycle over 4 cycles → each result appears exactly one cycle after its inputs. Assert rst in cycle 3 → outputs 0 at the following edge.
